// File: rtl/neo_pixel_receiver.sv
// NeoPixel single-wire receiver: measures high pulses, rebuilds 24-bit G/R/B words
// and reports each pixel plus end-of-frame status when the low latch period is seen.
module neo_pixel_receiver #(
  parameter int NUM_PIXELS   = 5,
  parameter int THRESH_HIGH  = 27,
  parameter int MIN_HIGH     = 8,
  parameter int MAX_HIGH     = 60,
  parameter int LATCH_CYCLES = 2500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       neo_in,
  output logic       pixel_valid,
  output logic [2:0] pixel_index,
  output logic [7:0] green,
  output logic [7:0] red,
  output logic [7:0] blue,
  output logic       frame_done,
  output logic       frame_error,
  output logic [3:0] pixels_received,
  output logic       busy
);

  localparam int LOW_W = $clog2(LATCH_CYCLES + 1);
  localparam logic [LOW_W-1:0] LATCH_L = LOW_W'(LATCH_CYCLES);
  localparam logic [6:0] MIN_H = 7'(MIN_HIGH);
  localparam logic [6:0] MAX_H = 7'(MAX_HIGH);
  localparam logic [6:0] THR_H = 7'(THRESH_HIGH);
  localparam logic [7:0] NUM_P = 8'(NUM_PIXELS);

  typedef enum logic [2:0] {SYNC, IDLE, HIGH, LOW, ERR} state_t;

  logic sync_p0, sync_p1, level_p2, rise_p2, fall_p2;

  state_t           state, state_nx;
  logic [6:0]       high_cnt, high_nx;
  logic [LOW_W-1:0] low_cnt, low_nx;
  logic [4:0]       bit_cnt, bit_nx;
  logic [7:0]       pixel_cnt, pixel_nx;
  logic [23:0]      shift_reg, shift_nx;
  logic             err_flag, err_nx;
  logic             pixel_valid_nx, frame_done_nx, frame_error_nx, busy_nx;
  logic [2:0]       pixel_index_nx;
  logic [23:0]      grb_nx;
  logic [3:0]       pixels_received_nx;
  logic             bit_val;
  logic [23:0]      new_word;
  logic [3:0]       pixel_sat;

  // Stage p0/p1: two-flop synchronizer; stage p2: registered level and edges
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      level_p2 <= 1'b0;
      rise_p2  <= 1'b0;
      fall_p2  <= 1'b0;
    end else begin
      sync_p0  <= neo_in;
      sync_p1  <= sync_p0;
      level_p2 <= sync_p1;
      rise_p2  <= sync_p1 & ~level_p2;
      fall_p2  <= ~sync_p1 & level_p2;
    end
  end

  // high_cnt holds the number of edges that sampled the line high; the rise itself counts as one.
  assign bit_val   = (high_cnt >= THR_H);
  assign new_word  = {bit_val, shift_reg[23:1]};
  assign pixel_sat = (pixel_cnt > 8'd15) ? 4'd15 : pixel_cnt[3:0];

  always_comb begin
    state_nx           = state;
    high_nx            = high_cnt;
    low_nx             = low_cnt;
    bit_nx             = bit_cnt;
    pixel_nx           = pixel_cnt;
    shift_nx           = shift_reg;
    err_nx             = err_flag;
    pixel_valid_nx     = 1'b0;
    pixel_index_nx     = pixel_index;
    grb_nx             = {green, red, blue};
    frame_done_nx      = 1'b0;
    frame_error_nx     = frame_error;
    pixels_received_nx = pixels_received;
    busy_nx            = busy;
    case (state)
      SYNC: begin
        if (level_p2) begin
          low_nx = '0;
        end else if ((low_cnt + LOW_W'(1)) == LATCH_L) begin
          low_nx   = '0;
          state_nx = IDLE;
        end else begin
          low_nx = low_cnt + LOW_W'(1);
        end
      end
      IDLE: begin
        if (rise_p2) begin
          high_nx  = 7'd1;
          bit_nx   = '0;
          pixel_nx = '0;
          err_nx   = 1'b0;
          busy_nx  = 1'b1;
          state_nx = HIGH;
        end
      end
      HIGH: begin
        if (fall_p2) begin
          low_nx = LOW_W'(1);
          if (high_cnt < MIN_H || high_cnt > MAX_H) begin
            err_nx   = 1'b1;
            state_nx = ERR;
          end else begin
            shift_nx = new_word;
            state_nx = LOW;
            if (bit_cnt == 5'd23) begin
              bit_nx = '0;
              if (pixel_cnt < NUM_P) begin
                pixel_valid_nx = 1'b1;
                pixel_index_nx = pixel_cnt[2:0];
                grb_nx         = new_word;
              end
              pixel_nx = (pixel_cnt != 8'hFF) ? pixel_cnt + 8'd1 : pixel_cnt;
            end else begin
              bit_nx = bit_cnt + 5'd1;
            end
          end
        end else if (high_cnt >= MAX_H) begin
          // this cycle's sample makes the width MAX_HIGH+1
          err_nx   = 1'b1;
          low_nx   = '0;
          state_nx = ERR;
        end else if (high_cnt != 7'd127) begin
          high_nx = high_cnt + 7'd1;
        end
      end
      LOW: begin
        if (rise_p2) begin
          high_nx  = 7'd1;
          state_nx = HIGH;
        end else if ((low_cnt + LOW_W'(1)) == LATCH_L) begin
          frame_done_nx      = 1'b1;
          frame_error_nx     = (bit_cnt != 5'd0) || (pixel_cnt > NUM_P) || err_flag;
          pixels_received_nx = pixel_sat;
          busy_nx            = 1'b0;
          low_nx             = '0;
          state_nx           = IDLE;
        end else begin
          low_nx = low_cnt + LOW_W'(1);
        end
      end
      ERR: begin
        if (level_p2) begin
          low_nx = '0;
        end else if ((low_cnt + LOW_W'(1)) == LATCH_L) begin
          frame_done_nx      = 1'b1;
          frame_error_nx     = 1'b1;
          pixels_received_nx = pixel_sat;
          busy_nx            = 1'b0;
          low_nx             = '0;
          state_nx           = IDLE;
        end else begin
          low_nx = low_cnt + LOW_W'(1);
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  // Stage p3: FSM state, counters and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= SYNC;
      high_cnt        <= '0;
      low_cnt         <= '0;
      bit_cnt         <= '0;
      pixel_cnt       <= '0;
      shift_reg       <= '0;
      err_flag        <= 1'b0;
      pixel_valid     <= 1'b0;
      pixel_index     <= '0;
      green           <= '0;
      red             <= '0;
      blue            <= '0;
      frame_done      <= 1'b0;
      frame_error     <= 1'b0;
      pixels_received <= '0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nx;
      high_cnt        <= high_nx;
      low_cnt         <= low_nx;
      bit_cnt         <= bit_nx;
      pixel_cnt       <= pixel_nx;
      shift_reg       <= shift_nx;
      err_flag        <= err_nx;
      pixel_valid     <= pixel_valid_nx;
      pixel_index     <= pixel_index_nx;
      {green, red, blue} <= grb_nx;
      frame_done      <= frame_done_nx;
      frame_error     <= frame_error_nx;
      pixels_received <= pixels_received_nx;
      busy            <= busy_nx;
    end
  end

endmodule

// File: doc/neo_pixel_receiver.md
Name: neo_pixel_receiver

Overview:
Decodes a single-wire NeoPixel bit stream back into per-pixel G/R/B words. It is the receive end of the team's strand controller protocol and is used as a loopback checker and as a front end for daisy-chained strand monitors. It measures each high pulse to recover bits, assembles 24-bit words, and reports each pixel on a one-cycle valid strobe. The 50 us low latch period is detected as end-of-frame, with frame status reported at that point.

Parameters:
NUM_PIXELS, 5, pixels per frame; words beyond this count are not emitted.
THRESH_HIGH, 27, high width in clocks at or above which a bit decodes as 1.
MIN_HIGH, 8, high widths below this are glitches and raise an error.
MAX_HIGH, 60, high widths above this raise an error.
LATCH_CYCLES, 2500, continuous low clocks that mark end-of-frame (50 us at 50 MHz).

Ports:
clock  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-high reset.
neo_in  input  1  asynchronous serial line.
pixel_valid  output  1  one-cycle strobe; pixel_index/green/red/blue are valid in that cycle.
pixel_index  output  3  pixel number within the frame (0-based).
green  output  8  decoded green byte.
red  output  8  decoded red byte.
blue  output  8  decoded blue byte.
frame_done  output  1  one-cycle strobe at latch detection.
frame_error  output  1  status of the last frame; updated with frame_done and held until the next frame_done.
pixels_received  output  4  complete words in the last frame; saturates at 15; updated with frame_done.
busy  output  1  high while inside a frame (from first rising edge until latch).

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clock.
- Reset values: all outputs are 0. The FSM enters SYNC and all counters and shift state clear.
- Input path: neo_in passes through a 2-flop synchronizer, then rise/fall detection on the synchronized signal.
- Output latency: outputs triggered by a neo_in edge appear exactly 3 clocks after the first clock edge that samples the new level.
- Width measurement: the measured high width equals the number of clock edges that sampled neo_in high.
- Bit order: bits arrive LSB-first over the packet. Frame bit k is bit (k mod 24) of word {G[7:0],R[7:0],B[7:0]} of pixel k/24. The first bit of a frame is B[0] of pixel 0.
- The shift register shifts right, inserting each new bit at bit 23.
- FSM states:
  - SYNC: the low counter counts synchronized-low clocks; any high clears it. Count reaching LATCH_CYCLES goes to IDLE. Pulses seen in SYNC are ignored and produce no outputs.
  - IDLE: on rise, clear the high counter, clear the bit/pixel counters and frame flags, assert busy, go to HIGH.
  - HIGH: the high counter increments and saturates at 127. Count exceeding MAX_HIGH sets the error flag and goes to ERR.
  - HIGH on fall: width < MIN_HIGH sets error and goes to ERR. Otherwise bit = (width >= THRESH_HIGH); shift it in, increment the bit counter (0..23) and go to LOW.
  - HIGH word completion: on the 24th bit the word is emitted and the bit counter wraps to 0. pixel_valid and the pixel outputs assert only when pixel count < NUM_PIXELS; the pixel count increments regardless.
  - LOW: the low counter increments. A rise clears the high counter and goes to HIGH. Low count reaching LATCH_CYCLES triggers end-of-frame.
  - End-of-frame: pulse frame_done, load pixels_received, deassert busy, go to IDLE.
  - End-of-frame error: frame_error = (bit counter != 0) OR (pixel count > NUM_PIXELS) OR error flag. A partial word is discarded.
  - ERR: no further pixel output. Wait for LATCH_CYCLES continuous low, with any high restarting the count. Then pulse frame_done with frame_error=1, deassert busy and go to IDLE.
- green/red/blue/pixel_index hold their last emitted values between strobes.
- Simultaneous events: end-of-frame and a rise cannot coincide, because latch requires low. A word completing on a fall and a MAX_HIGH overflow are mutually exclusive by state.
- Reset mid-frame: aborts immediately, with no frame_done. The next frame is accepted only after SYNC completes.
- No backpressure: the consumer must accept pixel_valid strobes. Successive strobes are at least 24 bit periods apart.

Test Plan:
- Reset, 2500 low, then one pixel G=0x12 R=0x34 B=0x56 sent LSB-first ('0' = 19 high/40 low, '1' = 36 high/30 low), then 2500 low -> one pixel_valid with index 0 and G/R/B 0x12/0x34/0x56; frame_done=1, frame_error=0, pixels_received=1, busy 0 after.
- Full 120-bit frame, pixels {0x00FF00,0x0000FF,0xFF0000,0xAAAAAA,0x555555} -> 5 strobes with indices 0..4 and matching values; pixels_received=5, frame_error=0.
- Threshold and glitch: high widths 26 -> 0, 27 -> 1, 8 -> accepted as 0; a 7-clock high -> ERR with no further strobes, and after latch frame_done=1, frame_error=1.
- Partial and overflow: 30 bits then latch -> 1 strobe, frame_error=1, pixels_received=1; 144 bits (6 words) -> 5 strobes, frame_error=1, pixels_received=6.
- Stuck high: neo_in held high for 100 clocks mid-frame -> ERR; frame_done with frame_error=1 only after 2500 low.
- Reset and sync: pulses within the first 2500 clocks after reset produce no outputs; reset asserted at bit 10 -> all outputs 0 immediately, and no output until 2500 low then a new frame.
